checkout_sequencer: RTL and testbench
=====================================

# checkout_sequencer

Sequences the end-of-shopping checkout over the basket storage. On a start request it walks the occupied basket slots one at a time and looks up each product's unit price. It multiplies price by quantity and accumulates a running total. It then reports total, item count and completion to the terminal state machine and the display path. It sits between the top-level state machine (start/abort in the end-shopping state) and the basket controller's read port and the price table.

## Interface
- SLOTS, 8: basket capacity; legal range 1..15
- PRICE_W, 8: unit-price width
- TOTAL_W, 16: accumulated-total width
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle checkout request
- Abort  in  1  cancel checkout in progress
- BasketProductNum  in  4  occupied-slot count from basket controller
- Slot_Addr  out  4  basket slot being read
- Slot_Rd  out  1  basket read strobe
- Slot_ProductID  in  4  basket read data, valid 1 cycle after Slot_Rd
- Slot_Quantity  in  4  basket read data, same timing
- Slot_Valid  in  1  slot-occupied flag, same timing
- Price_ID  out  4  product ID presented to the combinational price table
- Price_In  in  PRICE_W  unit price for Price_ID, same cycle
- Total  out  TOTAL_W  accumulated total
- Item_Count  out  4  number of slots accumulated
- Busy  out  1  high in READ, WAIT and ACC
- Done  out  1  one-cycle completion pulse
- Error  out  1  one-cycle pulse: Start with empty basket
- Overflow  out  1  sticky flag: total exceeded 2^TOTAL_W-1

## Operation
- States: IDLE, READ, WAIT, ACC, DONE. All outputs are registered or decoded from state.
- IDLE, Start=1, BasketProductNum=0:
  - pulse Error
  - stay IDLE
  - Total, Item_Count and Overflow unchanged
- IDLE, Start=1, BasketProductNum>0:
  - clear Total, Item_Count and Overflow
  - set address to 0
  - latch N = min(BasketProductNum, SLOTS)
  - go to READ
- READ: Slot_Addr = address, Slot_Rd = 1 for exactly this cycle; go to WAIT.
- WAIT: capture Slot_ProductID, Slot_Quantity and Slot_Valid into registers; go to ACC.
- ACC:
  - Price_ID = captured ID (held from WAIT onward)
  - If captured valid=1 and ID≠4'hF: product = Price_In × quantity, computed at PRICE_W+4 bits and zero-extended; add it to Total; Item_Count+1.
  - Otherwise the slot is skipped and neither Total nor Item_Count changes.
  - If the sum exceeds TOTAL_W bits: set Overflow; the stored result is per Configuration.
  - Address+1. If the new address == N go to DONE, else go to READ.
- DONE: Done=1 for one cycle; go to IDLE. Total and Item_Count hold until the next accepted Start or reset.
- Start while not in IDLE: ignored.
- Abort in READ, WAIT, ACC or DONE:
  - next state IDLE
  - Total=0, Item_Count=0
  - Done not pulsed
  - Abort has priority over all transitions.
- Abort in IDLE: no effect. Abort and Start in the same IDLE cycle: Start ignored.
- Reset values: state IDLE, all outputs 0 (Slot_Addr=0, Price_ID=0, Total=0). Reset takes effect immediately in any state, including mid-walk.

## Timing
- Start sampled at edge k. READ occupies cycle k+1.
- Each slot takes 3 cycles (READ, WAIT, ACC).
- Done is high in cycle k+1+3N. Busy is high from cycle k+1 through k+3N.
- Basket read latency is fixed at 1 cycle. Price lookup is combinational, 0 cycles.
- Total is updated at the end of each ACC cycle and is visible as a running sum.

## Configuration
- CHECKOUT_SATURATE_EN defined: on overflow, Total clamps to 2^TOTAL_W-1 and stays clamped for the rest of the walk.
- CHECKOUT_SATURATE_EN undefined: Total wraps modulo 2^TOTAL_W.
- Overflow is set in both builds.

## Test plan
- Price table: ID1=10, ID3=40. Basket (ID1,q2),(ID3,q1), N=2, Start at k -> Total=60, Item_Count=2, Done only in cycle k+7, Slot_Rd pulsed at k+1 and k+4.
- BasketProductNum=0, Start -> Error pulse of 1 cycle, Busy stays 0, no Done, previous Total retained.
- 3 slots with the middle slot Slot_Valid=0 (ID1 q1, X, ID3 q2) -> Total=90, Item_Count=2, Done at k+10.
- TOTAL_W=12; two slots of price 255 × q15 -> Overflow=1; Total=4095 with macro, Total=3554 without.
- Abort during WAIT of slot 1 -> IDLE next cycle, Total=0, no Done. A second Start issued while Busy has no effect.
- RESET asserted asynchronously during ACC -> all outputs 0 before the next edge; a fresh Start afterward gives the correct total.

Source files
------------

// File: rtl/checkout_sequencer.sv
// checkout_sequencer
// Walks the occupied basket slots after a checkout request, looks up each
// product's unit price, multiplies it by the quantity and accumulates a total.
// Reports the total, the number of accumulated slots and a completion pulse.
//
// Optional build macro: CHECKOUT_SATURATE_EN
//   defined   -> Total clamps to all-ones on overflow
//   undefined -> Total wraps modulo 2^TOTAL_W
// Overflow is flagged (sticky until the next accepted Start) in both builds.
module checkout_sequencer #(
    parameter int SLOTS   = 8,
    parameter int PRICE_W = 8,
    parameter int TOTAL_W = 16
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               Start,
    input  logic               Abort,
    input  logic [3:0]         BasketProductNum,
    output logic [3:0]         Slot_Addr,
    output logic               Slot_Rd,
    input  logic [3:0]         Slot_ProductID,
    input  logic [3:0]         Slot_Quantity,
    input  logic               Slot_Valid,
    output logic [3:0]         Price_ID,
    input  logic [PRICE_W-1:0] Price_In,
    output logic [TOTAL_W-1:0] Total,
    output logic [3:0]         Item_Count,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic               Overflow
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Product is computed at PRICE_W+4 bits; the sum gets one spare bit above
    // the wider of the total and the product so overflow is never lost.
    localparam int PROD_W = PRICE_W + 4;
    localparam int SUM_W  = ((TOTAL_W > PROD_W) ? TOTAL_W : PROD_W) + 1;

    localparam logic [3:0]         SLOTS_N   = 4'(SLOTS);
    localparam logic [TOTAL_W-1:0] TOTAL_ONE = {TOTAL_W{1'b1}};
    localparam logic [SUM_W-1:0]   TOTAL_MAX = {{(SUM_W-TOTAL_W){1'b0}}, TOTAL_ONE};

    logic [2:0]         state_q, state_d;
    logic [3:0]         addr_q, addr_d;
    logic [3:0]         n_q, n_d;
    logic [3:0]         id_q, id_d;
    logic [3:0]         qty_q, qty_d;
    logic               vld_q, vld_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [3:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [PROD_W-1:0]  prod_s;
    logic [SUM_W-1:0]   sum_s;
    logic               sum_ovf_s;
    logic [TOTAL_W-1:0] acc_total_s;
    logic               take_s;
    logic [3:0]         n_start_s;
    logic [3:0]         addr_inc_s;

    // Price x quantity, running-sum candidate and overflow detection.
    always_comb begin
        prod_s     = {4'b0000, Price_In} * {{PRICE_W{1'b0}}, qty_q};
        sum_s      = {{(SUM_W-TOTAL_W){1'b0}}, total_q} + {{(SUM_W-PROD_W){1'b0}}, prod_s};
        sum_ovf_s  = (sum_s > TOTAL_MAX);
`ifdef CHECKOUT_SATURATE_EN
        if (sum_ovf_s) begin
            acc_total_s = TOTAL_ONE;
        end else begin
            acc_total_s = sum_s[TOTAL_W-1:0];
        end
`else
        acc_total_s = sum_s[TOTAL_W-1:0];
`endif
        // ID 4'hF marks an unusable slot even when the occupied flag is set.
        take_s     = vld_q && (id_q != 4'hF);
        n_start_s  = (BasketProductNum > SLOTS_N) ? SLOTS_N : BasketProductNum;
        addr_inc_s = addr_q + 4'd1;
    end

    // Next-state and datapath update; Abort outside IDLE overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        n_d     = n_q;
        id_d    = id_q;
        qty_d   = qty_q;
        vld_d   = vld_q;
        total_d = total_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    if (BasketProductNum == 4'd0) begin
                        err_d = 1'b1;
                    end else begin
                        total_d = {TOTAL_W{1'b0}};
                        count_d = 4'd0;
                        ovf_d   = 1'b0;
                        addr_d  = 4'd0;
                        n_d     = n_start_s;
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Basket data arrives one cycle after the read strobe.
                id_d    = Slot_ProductID;
                qty_d   = Slot_Quantity;
                vld_d   = Slot_Valid;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (take_s) begin
                    total_d = acc_total_s;
                    count_d = count_q + 4'd1;
                    if (sum_ovf_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end else begin
                    total_d = total_q;
                end
                addr_d = addr_inc_s;
                if (addr_inc_s == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (Abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            total_d = {TOTAL_W{1'b0}};
            count_d = 4'd0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= 4'd0;
            n_q     <= 4'd0;
            id_q    <= 4'd0;
            qty_q   <= 4'd0;
            vld_q   <= 1'b0;
            total_q <= {TOTAL_W{1'b0}};
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            id_q    <= id_d;
            qty_q   <= qty_d;
            vld_q   <= vld_d;
            total_q <= total_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Outputs: registers or pure state decodes.
    always_comb begin
        Slot_Addr  = addr_q;
        Slot_Rd    = (state_q == ST_READ);
        Price_ID   = id_q;
        Total      = total_q;
        Item_Count = count_q;
        Busy       = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_ACC);
        Done       = (state_q == ST_DONE);
        Error      = err_q;
        Overflow   = ovf_q;
    end

endmodule

// File: tb/tb_checkout_sequencer.sv
// Self-checking bench for checkout_sequencer (TOTAL_W=12 so overflow is reachable).
module tb_checkout_sequencer;
    localparam int SLOTS   = 8;
    localparam int PRICE_W = 8;
    localparam int TOTAL_W = 12;

    logic               CLOCK_50 = 1'b0;
    logic               RESET = 1'b1;
    logic               Start = 1'b0;
    logic               Abort = 1'b0;
    logic [3:0]         BasketProductNum = 4'd0;
    logic [3:0]         Slot_Addr;
    logic               Slot_Rd;
    logic [3:0]         Slot_ProductID = 4'd0;
    logic [3:0]         Slot_Quantity = 4'd0;
    logic               Slot_Valid = 1'b0;
    logic [3:0]         Price_ID;
    logic [PRICE_W-1:0] Price_In;
    logic [TOTAL_W-1:0] Total;
    logic [3:0]         Item_Count;
    logic               Busy, Done, Error, Overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [TOTAL_W-1:0] total;
        logic [3:0]         count;
        logic               ovf;
    } exp_t;
    exp_t sb_q[$];

    logic [3:0] mem_id [16];
    logic [3:0] mem_qty[16];
    logic       mem_v  [16];

    // Walk observations
    int                 obs_done_off, obs_done_cnt, obs_err_cnt, obs_err_off;
    logic [63:0]        obs_rd, obs_busy;
    logic [TOTAL_W-1:0] obs_total;
    logic [3:0]         obs_count;
    logic               obs_ovf;

    checkout_sequencer #(.SLOTS(SLOTS), .PRICE_W(PRICE_W), .TOTAL_W(TOTAL_W)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .Start(Start), .Abort(Abort),
        .BasketProductNum(BasketProductNum), .Slot_Addr(Slot_Addr), .Slot_Rd(Slot_Rd),
        .Slot_ProductID(Slot_ProductID), .Slot_Quantity(Slot_Quantity), .Slot_Valid(Slot_Valid),
        .Price_ID(Price_ID), .Price_In(Price_In), .Total(Total), .Item_Count(Item_Count),
        .Busy(Busy), .Done(Done), .Error(Error), .Overflow(Overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int price_of(input logic [3:0] id);
        case (id)
            4'd1:    return 10;
            4'd3:    return 40;
            4'd5:    return 255;
            4'hE:    return 7;
            4'hF:    return 99;
            default: return 3 * int'(id);
        endcase
    endfunction

    assign Price_In = PRICE_W'(price_of(Price_ID));

    // Basket read port: data one cycle after the strobe, garbage otherwise.
    always @(posedge CLOCK_50) begin
        if (Slot_Rd) begin
            Slot_ProductID <= mem_id[Slot_Addr];
            Slot_Quantity  <= mem_qty[Slot_Addr];
            Slot_Valid     <= mem_v[Slot_Addr];
        end else begin
            Slot_ProductID <= 4'hE;
            Slot_Quantity  <= 4'hF;
            Slot_Valid     <= 1'b1;
        end
    end

    function automatic exp_t model(input int num);
        exp_t e;
        int   n, sum, cnt;
        bit   ovf;
        n = (num > SLOTS) ? SLOTS : num;
        sum = 0; cnt = 0; ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mem_v[i] && mem_id[i] != 4'hF) begin
                sum += price_of(mem_id[i]) * int'(mem_qty[i]);
                cnt++;
                if (sum > 4095) begin
                    ovf = 1'b1;
`ifdef CHECKOUT_SATURATE_EN
                    sum = 4095;
`else
                    sum = sum % 4096;
`endif
                end
            end
        end
        e.total = TOTAL_W'(sum);
        e.count = 4'(cnt);
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic set_slot(input int i, input logic [3:0] id, input logic [3:0] q, input logic v);
        mem_id[i] = id; mem_qty[i] = q; mem_v[i] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) set_slot(i, 4'hE, 4'hF, 1'b1);
    endtask

    // Issue Start and record outputs for offsets 1..bound after the Start edge.
    task automatic walk(input logic [3:0] bpn, input int bound);
        BasketProductNum = bpn;
        @(negedge CLOCK_50);
        Start = 1'b1;
        if (bpn != 4'd0) sb_q.push_back(model(int'(bpn)));
        @(negedge CLOCK_50);
        Start = 1'b0;
        obs_done_off = 0; obs_done_cnt = 0; obs_err_cnt = 0; obs_err_off = 0;
        obs_rd = 64'd0; obs_busy = 64'd0;
        obs_total = '0; obs_count = 4'd0; obs_ovf = 1'b0;
        for (int off = 1; off <= bound; off++) begin
            if (Slot_Rd) obs_rd[off] = 1'b1;
            if (Busy) obs_busy[off] = 1'b1;
            if (Error) begin obs_err_cnt++; if (obs_err_off == 0) obs_err_off = off; end
            if (Done) begin
                obs_done_cnt++;
                if (obs_done_off == 0) begin
                    obs_done_off = off; obs_total = Total; obs_count = Item_Count; obs_ovf = Overflow;
                end
            end
            if (off < bound) @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        n_checks++; if (Total !== 12'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", Total); end
        n_checks++; if (Item_Count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Item_Count); end
        n_checks++; if ({Busy, Done, Error, Overflow, Slot_Rd} !== 5'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {Busy, Done, Error, Overflow, Slot_Rd}); end
        n_checks++; if ({Slot_Addr, Price_ID} !== 8'd0) begin n_fail++; $display("FAIL reset_addr_id: got %h expected 00", {Slot_Addr, Price_ID}); end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        clear_mem();
        set_slot(0, 4'd1, 4'd2, 1'b1);
        set_slot(1, 4'd3, 4'd1, 1'b1);
        walk(4'd2, 9);
        e = sb_q.pop_front();
        n_checks++; if (obs_total !== e.total || obs_total !== 12'd60) begin n_fail++; $display("FAIL basic_total: got %0d expected %0d", obs_total, e.total); end
        n_checks++; if (obs_count !== e.count) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_count, e.count); end
        n_checks++; if (obs_done_off != 7 || obs_done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got off %0d cnt %0d expected off 7 cnt 1", obs_done_off, obs_done_cnt); end
        n_checks++; if (obs_rd !== 64'h12) begin n_fail++; $display("FAIL basic_rd: got %h expected 12", obs_rd); end
        n_checks++; if (obs_busy !== 64'h7E) begin n_fail++; $display("FAIL basic_busy: got %h expected 7e", obs_busy); end
        n_checks++; if (Total !== 12'd60 || Item_Count !== 4'd2) begin n_fail++; $display("FAIL basic_hold: got %0d/%0d expected 60/2", Total, Item_Count); end
    endtask

    task automatic test_empty();
        walk(4'd0, 6);
        n_checks++; if (obs_err_cnt != 1 || obs_err_off != 1) begin n_fail++; $display("FAIL empty_error: got cnt %0d off %0d expected cnt 1 off 1", obs_err_cnt, obs_err_off); end
        n_checks++; if (obs_busy !== 64'd0 || obs_done_cnt != 0) begin n_fail++; $display("FAIL empty_busy_done: got busy %h done %0d expected 0 0", obs_busy, obs_done_cnt); end
        n_checks++; if (Total !== 12'd60 || Item_Count !== 4'd2) begin n_fail++; $display("FAIL empty_retain: got %0d/%0d expected 60/2", Total, Item_Count); end
    endtask

    task automatic test_skip();
        exp_t e;
        clear_mem();
        set_slot(0, 4'd1, 4'd1, 1'b1);
        set_slot(1, 4'd3, 4'd9, 1'b0);
        set_slot(2, 4'd3, 4'd2, 1'b1);
        walk(4'd3, 12);
        e = sb_q.pop_front();
        n_checks++; if (obs_total !== e.total || obs_total !== 12'd90) begin n_fail++; $display("FAIL skip_total: got %0d expected %0d", obs_total, e.total); end
        n_checks++; if (obs_count !== e.count || obs_count !== 4'd2) begin n_fail++; $display("FAIL skip_count: got %0d expected %0d", obs_count, e.count); end
        n_checks++; if (obs_done_off != 10 || obs_rd !== 64'h92) begin n_fail++; $display("FAIL skip_timing: got done %0d rd %h expected 10 92", obs_done_off, obs_rd); end
    endtask

    task automatic test_idf_clamp();
        exp_t e;
        clear_mem();
        for (int i = 0; i < 8; i++) set_slot(i, 4'(i + 1), 4'(i + 1), 1'b1);
        set_slot(2, 4'hF, 4'd3, 1'b1);
        walk(4'd12, 28);
        e = sb_q.pop_front();
        n_checks++; if (obs_done_off != 25 || obs_done_cnt != 1) begin n_fail++; $display("FAIL clamp_done: got off %0d cnt %0d expected 25 1", obs_done_off, obs_done_cnt); end
        n_checks++; if (obs_total !== e.total || obs_count !== e.count || obs_count !== 4'd7) begin n_fail++; $display("FAIL clamp_result: got %0d/%0d expected %0d/%0d", obs_total, obs_count, e.total, e.count); end
    endtask

    task automatic test_overflow();
        exp_t e;
        logic [TOTAL_W-1:0] want;
`ifdef CHECKOUT_SATURATE_EN
        want = 12'd4095;
`else
        want = 12'd3554;
`endif
        clear_mem();
        set_slot(0, 4'd5, 4'd15, 1'b1);
        set_slot(1, 4'd5, 4'd15, 1'b1);
        walk(4'd2, 9);
        e = sb_q.pop_front();
        n_checks++; if (obs_ovf !== 1'b1 || e.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", obs_ovf); end
        n_checks++; if (obs_total !== e.total || obs_total !== want) begin n_fail++; $display("FAIL ovf_total: got %0d expected %0d", obs_total, want); end
        n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", Overflow); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        clear_mem();
        set_slot(0, 4'd1, 4'd2, 1'b1);
        set_slot(1, 4'd3, 4'd1, 1'b1);
        for (int r = 0; r < 2; r++) begin
            walk(4'd2, 7);
            e = sb_q.pop_front();
            n_checks++; if (obs_done_off != 7 || obs_total !== e.total || obs_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_run%0d: got done %0d total %0d ovf %b expected 7 %0d 0", r, obs_done_off, obs_total, obs_ovf, e.total); end
        end
    endtask

    task automatic test_abort();
        int busy_seen, done_seen;
        BasketProductNum = 4'd2;
        @(negedge CLOCK_50); Start = 1'b1;
        @(negedge CLOCK_50); Start = 1'b0;          // offset 1 READ
        @(negedge CLOCK_50); Start = 1'b1;          // offset 2 WAIT, must be ignored
        @(negedge CLOCK_50); Start = 1'b0;          // offset 3 ACC
        @(negedge CLOCK_50);                        // offset 4 READ slot 1
        n_checks++; if (Total !== 12'd20 || Item_Count !== 4'd1) begin n_fail++; $display("FAIL abort_running: got %0d/%0d expected 20/1", Total, Item_Count); end
        @(negedge CLOCK_50); Abort = 1'b1;          // offset 5 WAIT slot 1
        @(negedge CLOCK_50); Abort = 1'b0;          // offset 6
        n_checks++; if (Busy !== 1'b0 || Total !== 12'd0 || Item_Count !== 4'd0) begin n_fail++; $display("FAIL abort_clear: got busy %b total %0d count %0d expected 0 0 0", Busy, Total, Item_Count); end
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            if (Busy) busy_seen++;
            if (Done) done_seen++;
        end
        n_checks++; if (busy_seen != 0 || done_seen != 0) begin n_fail++; $display("FAIL abort_quiet: got busy %0d done %0d expected 0 0", busy_seen, done_seen); end
        Abort = 1'b1; Start = 1'b1;
        @(negedge CLOCK_50); Abort = 1'b0; Start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (Busy || Error) busy_seen++;
            @(negedge CLOCK_50);
        end
        n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL abort_start_idle: got %0d active cycles expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        BasketProductNum = 4'd2;
        @(negedge CLOCK_50); Start = 1'b1;
        @(negedge CLOCK_50); Start = 1'b0;
        repeat (5) @(negedge CLOCK_50);             // offset 6: ACC of slot 1
        n_checks++; if (Busy !== 1'b1 || Total !== 12'd20 || Price_ID !== 4'd3) begin n_fail++; $display("FAIL rstmid_pre: got busy %b total %0d id %0d expected 1 20 3", Busy, Total, Price_ID); end
        #2 RESET = 1'b1;
        #1;
        n_checks++; if ({Total, Item_Count, Slot_Addr, Price_ID} !== 24'd0 || {Busy, Done, Error, Overflow, Slot_Rd} !== 5'd0) begin n_fail++; $display("FAIL rstmid_async: got %h %b expected all 0", {Total, Item_Count, Slot_Addr, Price_ID}, {Busy, Done, Error, Overflow, Slot_Rd}); end
        @(negedge CLOCK_50); RESET = 1'b0;
        walk(4'd2, 7);
        e = sb_q.pop_front();
        n_checks++; if (obs_done_off != 7 || obs_total !== e.total || obs_count !== e.count) begin n_fail++; $display("FAIL rstmid_after: got done %0d %0d/%0d expected 7 %0d/%0d", obs_done_off, obs_total, obs_count, e.total, e.count); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_empty();
        test_skip();
        test_idf_clamp();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
